// File: rtl/commit_checker.sv
// Commit-stream checker: waits for each table PC to commit in order, probes the
// register file one cycle later and verdicts PASS, FAIL (mismatch) or FAIL (timeout).
module commit_checker #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [31:0]              cfg_pc,
    input  logic [4:0]               cfg_reg,
    input  logic [31:0]              cfg_val,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   num_entries,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    output logic [4:0]               chk_rsel,
    input  logic [31:0]              chk_rdata,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [31:0]              fail_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);
    localparam logic [AW:0]   ENT_ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CMP,
        S_PASS,
        S_FAIL
    } state_t;

    state_t         state_q;
    logic [AW-1:0]  idx_q;
    logic [CW-1:0]  cnt_q;
    logic [4:0]     rsel_q;
    logic           timeout_q;
    logic [AW-1:0]  fail_idx_q;
    logic [31:0]    fail_data_q;

    logic [31:0]    tbl_pc_q  [DEPTH];
    logic [4:0]     tbl_reg_q [DEPTH];
    logic [31:0]    tbl_val_q [DEPTH];

    logic           idle_like;
    logic           expired;
    logic           pc_hit;
    logic           val_hit;
    logic           last_entry;

    assign idle_like  = (state_q == S_IDLE) || (state_q == S_PASS) || (state_q == S_FAIL);
    assign expired    = (cnt_q == CNT_MAX);
    assign pc_hit     = commit_valid && (commit_pc == tbl_pc_q[idx_q]);
    assign val_hit    = (chk_rdata == tbl_val_q[idx_q]);
    assign last_entry = ({1'b0, idx_q} == (num_entries - ENT_ONE));

    // Table is frozen while a check is in flight so the expectations cannot shift under it.
    always_ff @(posedge clk) begin
        if (!reset && cfg_we && idle_like) begin
            tbl_pc_q[cfg_addr]  <= cfg_pc;
            tbl_reg_q[cfg_addr] <= cfg_reg;
            tbl_val_q[cfg_addr] <= cfg_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            rsel_q      <= '0;
            timeout_q   <= 1'b0;
            fail_idx_q  <= '0;
            fail_data_q <= '0;
        end else begin
            case (state_q)
                S_RUN, S_CMP: begin
                    // Budget exhaustion wins over whatever the compare would have decided.
                    if (expired) begin
                        state_q    <= S_FAIL;
                        timeout_q  <= 1'b1;
                        fail_idx_q <= idx_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (state_q == S_RUN) begin
                            if (pc_hit) begin
                                state_q <= S_CMP;
                                rsel_q  <= tbl_reg_q[idx_q];
                            end
                        end else if (!val_hit) begin
                            state_q     <= S_FAIL;
                            fail_idx_q  <= idx_q;
                            fail_data_q <= chk_rdata;
                        end else if (last_entry) begin
                            state_q <= S_PASS;
                        end else begin
                            idx_q   <= idx_q + IDX_ONE;
                            state_q <= S_RUN;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        timeout_q   <= 1'b0;
                        fail_idx_q  <= '0;
                        fail_data_q <= '0;
                        state_q     <= (num_entries == '0) ? S_PASS : S_RUN;
                    end
                end
            endcase
        end
    end

    assign chk_rsel  = rsel_q;
    assign done      = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass      = (state_q == S_PASS);
    assign timeout   = timeout_q;
    assign fail_idx  = fail_idx_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_commit_checker.sv
// Bench for commit_checker: directed scenarios with literal expectations, then
// randomized runs compared every cycle against a behavioural model of the checker.
module tb_commit_checker;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_pc;
    logic [4:0]  cfg_reg;
    logic [31:0] cfg_val;
    logic        start;
    logic [3:0]  num_entries;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [4:0]  chk_rsel;
    logic [31:0] chk_rdata;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [2:0]  fail_idx;
    logic [31:0] fail_data;

    logic [31:0] rf [32];
    assign chk_rdata = rf[chk_rsel];

    commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pc(cfg_pc), .cfg_reg(cfg_reg), .cfg_val(cfg_val), .start(start),
        .num_entries(num_entries), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .chk_rsel(chk_rsel), .chk_rdata(chk_rdata), .done(done), .pass(pass),
        .timeout(timeout), .fail_idx(fail_idx), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_WAIT, M_CHECK, M_PASSED, M_FAILED} mode_t;
    mode_t       mode = M_IDLE;
    logic [2:0]  m_pos = '0;
    int          m_elapsed = 0;
    logic        m_to = 1'b0;
    logic [2:0]  m_fidx = '0;
    logic [31:0] m_fdata = '0;
    logic [4:0]  m_rsel = '0;
    logic [31:0] m_pc  [DEPTH];
    logic [4:0]  m_reg [DEPTH];
    logic [31:0] m_val [DEPTH];

    function automatic bit active();
        return (mode == M_WAIT) || (mode == M_CHECK);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mode = M_IDLE; m_pos = '0; m_elapsed = 0; m_to = 1'b0;
            m_fidx = '0; m_fdata = '0; m_rsel = '0;
        end else if (active()) begin
            if (m_elapsed == TO - 1) begin
                mode = M_FAILED; m_to = 1'b1; m_fidx = m_pos;
            end else begin
                m_elapsed++;
                if (mode == M_WAIT) begin
                    if (commit_valid && commit_pc == m_pc[m_pos]) begin
                        mode = M_CHECK; m_rsel = m_reg[m_pos];
                    end
                end else if (rf[m_rsel] !== m_val[m_pos]) begin
                    mode = M_FAILED; m_fidx = m_pos; m_fdata = rf[m_rsel];
                end else if (int'(m_pos) + 1 == int'(num_entries)) begin
                    mode = M_PASSED;
                end else begin
                    m_pos = m_pos + 3'd1; mode = M_WAIT;
                end
            end
        end else begin
            if (cfg_we) begin
                m_pc[cfg_addr] = cfg_pc; m_reg[cfg_addr] = cfg_reg; m_val[cfg_addr] = cfg_val;
            end
            if (start) begin
                m_pos = '0; m_elapsed = 0; m_to = 1'b0; m_fidx = '0; m_fdata = '0;
                mode = (num_entries == 4'd0) ? M_PASSED : M_WAIT;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_done",      32'(done),      32'(mode == M_PASSED || mode == M_FAILED));
            check("cyc_pass",      32'(pass),      32'(mode == M_PASSED));
            check("cyc_timeout",   32'(timeout),   32'(m_to));
            check("cyc_fail_idx",  32'(fail_idx),  32'(m_fidx));
            check("cyc_fail_data", fail_data,      m_fdata);
            check("cyc_chk_rsel",  32'(chk_rsel),  32'(m_rsel));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] pc, input logic [4:0] r, input logic [31:0] v);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_pc = pc; cfg_reg = r; cfg_val = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic load_ref();
        load(0, 32'h1c, 5'd5, 32'd1);
        load(1, 32'h24, 5'd5, 32'd0);
        load(2, 32'h2c, 5'd5, 32'd0);
        load(3, 32'h34, 5'd5, 32'd0);
        load(4, 32'h3c, 5'd5, 32'd1);
    endtask

    task automatic start_run(input int n);
        num_entries = 4'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic commit_cmp(input logic [31:0] pc, input logic [31:0] data);
        rf[5] = data; commit_valid = 1'b1; commit_pc = pc;
        tick();
        commit_valid = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_pc = '0; cfg_reg = '0; cfg_val = '0;
        start = 1'b0; num_entries = '0; commit_valid = 1'b0; commit_pc = '0;
        tick();
        reset = 1'b0;
        cmp_en = 1'b1;

        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_fail_idx", 32'(fail_idx), 32'd0);
        check("rst_fail_data", fail_data, 32'd0);
        check("rst_chk_rsel", 32'(chk_rsel), 32'd0);

        // in-order pass
        load_ref();
        start_run(5);
        commit_cmp(32'h1c, 32'd1);
        commit_cmp(32'h24, 32'd0);
        commit_cmp(32'h2c, 32'd0);
        commit_cmp(32'h34, 32'd0);
        rf[5] = 32'd1; commit_valid = 1'b1; commit_pc = 32'h3c;
        tick();
        commit_valid = 1'b0;
        check("inorder_done_during_cmp", 32'(done), 32'd0);
        check("inorder_rsel", 32'(chk_rsel), 32'd5);
        tick();
        check("inorder_pass", 32'(pass), 32'd1);
        check("inorder_done", 32'(done), 32'd1);

        // mismatch on the last entry
        start_run(5);
        commit_cmp(32'h1c, 32'd1);
        commit_cmp(32'h24, 32'd0);
        commit_cmp(32'h2c, 32'd0);
        commit_cmp(32'h34, 32'd0);
        commit_cmp(32'h3c, 32'd0);
        check("mism_done", 32'(done), 32'd1);
        check("mism_pass", 32'(pass), 32'd0);
        check("mism_fail_idx", 32'(fail_idx), 32'd4);
        check("mism_fail_data", fail_data, 32'd0);
        check("mism_timeout", 32'(timeout), 32'd0);

        // mismatch with a distinctive probe value
        start_run(2);
        commit_cmp(32'h1c, 32'd1);
        commit_cmp(32'h24, 32'hdead_beef);
        check("mism2_fail_idx", 32'(fail_idx), 32'd1);
        check("mism2_fail_data", fail_data, 32'hdead_beef);

        // timeout
        load(0, 32'h40, 5'd5, 32'd3);
        start_run(1);
        repeat (TO - 1) tick();
        check("to_done_early", 32'(done), 32'd0);
        tick();
        check("to_done", 32'(done), 32'd1);
        check("to_pass", 32'(pass), 32'd0);
        check("to_timeout", 32'(timeout), 32'd1);
        check("to_fail_idx", 32'(fail_idx), 32'd0);

        // ordering, then empty run
        do_reset();
        load_ref();
        start_run(5);
        rf[5] = 32'd0; commit_valid = 1'b1; commit_pc = 32'h24;
        tick();
        commit_valid = 1'b0;
        tick();
        check("order_no_cmp_rsel", 32'(chk_rsel), 32'd0);
        check("order_no_done", 32'(done), 32'd0);
        commit_cmp(32'h1c, 32'd1);
        check("order_first_ok", 32'(done), 32'd0);
        do_reset();
        start_run(0);
        check("empty_pass", 32'(pass), 32'd1);
        check("empty_done", 32'(done), 32'd1);

        // reset during CMP; cfg_we during RUN must be ignored
        start_run(5);
        load(0, 32'h99, 5'd7, 32'd7);
        rf[5] = 32'd1; commit_valid = 1'b1; commit_pc = 32'h1c;
        tick();
        commit_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_pass", 32'(pass), 32'd0);
        check("rstmid_rsel", 32'(chk_rsel), 32'd0);
        check("rstmid_timeout", 32'(timeout), 32'd0);
        start_run(1);
        commit_cmp(32'h1c, 32'd1);
        check("table_kept_pass", 32'(pass), 32'd1);

        // back-to-back commit during CMP is dropped
        do_reset();
        start_run(5);
        rf[5] = 32'd1; commit_valid = 1'b1; commit_pc = 32'h1c;
        tick();
        commit_pc = 32'h24;
        tick();
        commit_valid = 1'b0;
        tick();
        check("b2b_not_done", 32'(done), 32'd0);
        commit_cmp(32'h24, 32'd0);
        commit_cmp(32'h2c, 32'd0);
        commit_cmp(32'h34, 32'd0);
        commit_cmp(32'h3c, 32'd1);
        check("b2b_pass", 32'(pass), 32'd1);

        // randomized runs
        for (int r = 0; r < 250; r++) begin
            int c;
            if ($urandom % 4 == 0) do_reset();
            for (int k = 0; k < int'($urandom_range(0, 8)); k++) begin
                logic [31:0] v;
                v = ($urandom % 3 == 0) ? $urandom : 32'($urandom % 2);
                load(int'($urandom % 8), 32'h100 + 32'(4 * $urandom_range(0, 7)), 5'($urandom), v);
            end
            start_run(int'($urandom_range(0, 8)));
            c = 0;
            while (active() && c < 40) begin
                cfg_we = ($urandom % 10 == 0);
                cfg_addr = 3'($urandom); cfg_pc = 32'h100 + 32'(4 * $urandom_range(0, 7));
                cfg_reg = 5'($urandom); cfg_val = $urandom;
                start = ($urandom % 12 == 0);
                num_entries = num_entries;
                reset = ($urandom % 50 == 0);
                commit_valid = ($urandom % 3 != 0);
                commit_pc = ($urandom % 2 == 0) ? m_pc[m_pos]
                                                : 32'h100 + 32'(4 * $urandom_range(0, 7));
                if (commit_valid && mode == M_WAIT && commit_pc == m_pc[m_pos])
                    rf[m_reg[m_pos]] = ($urandom % 6 == 0) ? $urandom : m_val[m_pos];
                tick();
                c++;
            end
            cfg_we = 1'b0; start = 1'b0; reset = 1'b0; commit_valid = 1'b0;
            check("run_within_bound", 32'(c >= 40), 32'd0);
            tick();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
